// File: rtl/button_debounce_if.sv
// Button conditioning bundle: raw pins in, debounced levels and edge pulses out.
interface button_debounce_if #(
    parameter int unsigned N = 4
) ();
    logic [N-1:0] BUTTONS_RAW;
    logic [N-1:0] BUTTONS_OUT;
    logic [N-1:0] PRESSED;
    logic [N-1:0] RELEASED;

    modport master (
        output BUTTONS_RAW,
        input  BUTTONS_OUT,
        input  PRESSED,
        input  RELEASED
    );

    modport slave (
        input  BUTTONS_RAW,
        output BUTTONS_OUT,
        output PRESSED,
        output RELEASED
    );
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus independent per-channel debounce counters.
// Macro BUTTON_DEBOUNCE_EDGE_EN compiles in the PRESSED/RELEASED pulse logic.
module button_debounce #(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input logic              CLK,
    input logic              RESET,
    button_debounce_if.slave bus
);
    typedef enum logic {StIdle, StCount} state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic   [N-1:0]     s1_q, s2_q;
    logic   [N-1:0]     stable_q, stable_d;
    logic   [N-1:0]     flip;
    state_e             state_q [N];
    state_e             state_d [N];
    logic   [CNT_W-1:0] cnt_q   [N];
    logic   [CNT_W-1:0] cnt_d   [N];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q     <= bus.BUTTONS_RAW;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // A channel flips once s2 has disagreed with the stable level for DEBOUNCE_CYCLES samples.
    always_comb begin
        flip = '0;
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StIdle: begin
                    cnt_d[i] = '0;
                    if (s2_q[i] != stable_q[i]) begin
                        if (cnt_q[i] == CntMax) begin
                            flip[i] = 1'b1;
                        end else begin
                            cnt_d[i]   = cnt_q[i] + 1'b1;
                            state_d[i] = StCount;
                        end
                    end
                end
                StCount: begin
                    if (s2_q[i] == stable_q[i]) begin
                        cnt_d[i]   = '0;
                        state_d[i] = StIdle;
                    end else if (cnt_q[i] == CntMax) begin
                        flip[i]    = 1'b1;
                        cnt_d[i]   = '0;
                        state_d[i] = StIdle;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    cnt_d[i]   = '0;
                    state_d[i] = StIdle;
                end
            endcase
        end
        stable_d = (stable_q & ~flip) | (s2_q & flip);
    end

    assign bus.BUTTONS_OUT = stable_q;

`ifdef BUTTON_DEBOUNCE_EDGE_EN
    logic [N-1:0] pressed_q, pressed_d;
    logic [N-1:0] released_q, released_d;

    always_comb begin
        pressed_d  = flip & s2_q;
        released_d = flip & ~s2_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pressed_q  <= '0;
            released_q <= '0;
        end else begin
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign bus.PRESSED  = pressed_q;
    assign bus.RELEASED = released_q;
`else
    assign bus.PRESSED  = '0;
    assign bus.RELEASED = '0;
`endif
endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with DEBOUNCE_CYCLES=4, CNT_W=3.
module tb_button_debounce;
`ifdef BUTTON_DEBOUNCE_EDGE_EN
    localparam bit EdgeEn = 1'b1;
`else
    localparam bit EdgeEn = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        logic [3:0] out;
        logic [3:0] prs;
        logic [3:0] rel;
    } step_t;

    typedef struct {
        logic [3:0] out;
        logic [3:0] prs;
        logic [3:0] rel;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    step_t stim_q [$];
    exp_t  sb     [$];

    button_debounce_if #(.N(4)) bus ();

    button_debounce #(
        .N              (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pulse(input logic [3:0] v);
        return EdgeEn ? v : 4'b0000;
    endfunction

    task automatic add(input logic r, input logic [3:0] raw, input int n,
                       input logic [3:0] out, input logic [3:0] prs, input logic [3:0] rel);
        for (int i = 0; i < n; i++) stim_q.push_back('{r, raw, out, prs, rel});
    endtask

    // Raw level first sampled at edge k; output flips at edge k+5 with a one-cycle pulse.
    task automatic add_change(input logic [3:0] raw, input logic [3:0] old_v,
                              input logic [3:0] new_v);
        add(1'b0, raw, 5, old_v, 4'b0000, 4'b0000);
        add(1'b0, raw, 1, new_v, pulse(new_v & ~old_v), pulse(old_v & ~new_v));
        add(1'b0, raw, 2, new_v, 4'b0000, 4'b0000);
    endtask

    task automatic test_reset();
        step_t s;
        exp_t  e;
        add(1'b1, 4'b1111, 3, 4'b0000, 4'b0000, 4'b0000);
        add_change(4'b1111, 4'b0000, 4'b1111);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst = s.rst;
            bus.BUTTONS_RAW = s.raw;
            sb.push_back('{s.out, s.prs, s.rel});
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (bus.BUTTONS_OUT !== e.out || bus.PRESSED !== e.prs || bus.RELEASED !== e.rel) begin
                n_bad++;
                $display("FAIL reset_held t=%0t: got out=%b prs=%b rel=%b, want out=%b prs=%b rel=%b",
                         $time, bus.BUTTONS_OUT, bus.PRESSED, bus.RELEASED, e.out, e.prs, e.rel);
            end
        end
    endtask

    task automatic test_clean_press();
        step_t s;
        exp_t  e;
        add_change(4'b0000, 4'b1111, 4'b0000);
        add_change(4'b0001, 4'b0000, 4'b0001);
        add_change(4'b0000, 4'b0001, 4'b0000);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst = s.rst;
            bus.BUTTONS_RAW = s.raw;
            sb.push_back('{s.out, s.prs, s.rel});
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (bus.BUTTONS_OUT !== e.out || bus.PRESSED !== e.prs || bus.RELEASED !== e.rel) begin
                n_bad++;
                $display("FAIL clean_press t=%0t: got out=%b prs=%b rel=%b, want out=%b prs=%b rel=%b",
                         $time, bus.BUTTONS_OUT, bus.PRESSED, bus.RELEASED, e.out, e.prs, e.rel);
            end
        end
    endtask

    task automatic test_bounce();
        step_t s;
        exp_t  e;
        add(1'b0, 4'b0100, 2, 4'b0000, 4'b0000, 4'b0000);
        add(1'b0, 4'b0000, 2, 4'b0000, 4'b0000, 4'b0000);
        add(1'b0, 4'b0100, 2, 4'b0000, 4'b0000, 4'b0000);
        add(1'b0, 4'b0000, 2, 4'b0000, 4'b0000, 4'b0000);
        add_change(4'b0100, 4'b0000, 4'b0100);
        add(1'b0, 4'b0100, 3, 4'b0100, 4'b0000, 4'b0000);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst = s.rst;
            bus.BUTTONS_RAW = s.raw;
            sb.push_back('{s.out, s.prs, s.rel});
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (bus.BUTTONS_OUT !== e.out || bus.PRESSED !== e.prs || bus.RELEASED !== e.rel) begin
                n_bad++;
                $display("FAIL bounce t=%0t: got out=%b prs=%b rel=%b, want out=%b prs=%b rel=%b",
                         $time, bus.BUTTONS_OUT, bus.PRESSED, bus.RELEASED, e.out, e.prs, e.rel);
            end
        end
    endtask

    task automatic test_simultaneous();
        step_t s;
        exp_t  e;
        add_change(4'b0000, 4'b0100, 4'b0000);
        add_change(4'b1010, 4'b0000, 4'b1010);
        add_change(4'b0000, 4'b1010, 4'b0000);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst = s.rst;
            bus.BUTTONS_RAW = s.raw;
            sb.push_back('{s.out, s.prs, s.rel});
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (bus.BUTTONS_OUT !== e.out || bus.PRESSED !== e.prs || bus.RELEASED !== e.rel) begin
                n_bad++;
                $display("FAIL simultaneous t=%0t: got out=%b prs=%b rel=%b, want out=%b prs=%b rel=%b",
                         $time, bus.BUTTONS_OUT, bus.PRESSED, bus.RELEASED, e.out, e.prs, e.rel);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        step_t s;
        exp_t  e;
        // Partial count of 3 samples, then a 2-cycle reset must restart the full latency.
        add(1'b0, 4'b0010, 3, 4'b0000, 4'b0000, 4'b0000);
        add(1'b1, 4'b0010, 2, 4'b0000, 4'b0000, 4'b0000);
        add_change(4'b0010, 4'b0000, 4'b0010);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst = s.rst;
            bus.BUTTONS_RAW = s.raw;
            sb.push_back('{s.out, s.prs, s.rel});
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (bus.BUTTONS_OUT !== e.out || bus.PRESSED !== e.prs || bus.RELEASED !== e.rel) begin
                n_bad++;
                $display("FAIL reset_mid_count t=%0t: got out=%b prs=%b rel=%b, want out=%b prs=%b rel=%b",
                         $time, bus.BUTTONS_OUT, bus.PRESSED, bus.RELEASED, e.out, e.prs, e.rel);
            end
        end
        // Reset between edges must clear the held output without waiting for a clock.
        rst = 1'b1;
        #2;
        n_cmp++;
        if (bus.BUTTONS_OUT !== 4'b0000 || bus.PRESSED !== 4'b0000 || bus.RELEASED !== 4'b0000) begin
            n_bad++;
            $display("FAIL async_reset t=%0t: got out=%b prs=%b rel=%b, want all 0000",
                     $time, bus.BUTTONS_OUT, bus.PRESSED, bus.RELEASED);
        end
        tick();
        bus.BUTTONS_RAW = 4'b0000;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.BUTTONS_RAW = 4'b1111;
        #3;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
